// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared opcodes, funct3 width codes and memory-stage FSM states
package rv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  // Any funct3 outside the byte/half codes behaves as a word access.
  function automatic size_e access_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: access_size = SZ_BYTE;
      F3_H, F3_HU: access_size = SZ_HALF;
      default:     access_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic [1:0] size_offset(input size_e sz, input logic [1:0] a);
    case (sz)
      SZ_BYTE: size_offset = a;
      SZ_HALF: size_offset = {a[1], 1'b0};
      default: size_offset = 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] a);
    case (sz)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = a[0];
      default: is_misaligned = (a != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects the load lane from a read word and sign/zero-extends it
module load_align
  import rv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign shifted = rdata >> {offset, 3'b000};
  assign lane_b  = shifted[7:0];
  assign lane_h  = shifted[15:0];

  always_comb begin
    result = rdata;
    case (funct3)
      F3_B:    result = {{24{lane_b[7]}}, lane_b};
      F3_H:    result = {{16{lane_h[15]}}, lane_h};
      F3_BU:   result = {24'd0, lane_b};
      F3_HU:   result = {16'd0, lane_h};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// rtl/memory_access.sv - pipeline memory stage: issues loads/stores, returns results to write-back
// Optional MEM_MISALIGN_TRAP_EN: adds misalign output and traps misaligned accesses instead of masking.
module memory_access
  import rv_pkg::*;
#(
  parameter int MEM_AW = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_ir,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_a,
  input  logic [31:0]       in_b,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              out_valid,
  output logic [31:0]       IR,
  output logic [31:0]       RD,
  output logic [31:0]       A,
  output logic [31:0]       PC
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              misalign
`endif
);

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       rd_q, rd_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       pc_q, pc_d;

  size_e       in_size;
  logic [1:0]  in_off;
  logic        in_is_load;
  logic        in_is_store;
  logic        in_trap;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_result;
  logic        cur_is_load;

  assign in_size     = access_size(in_ir[14:12]);
  assign in_off      = size_offset(in_size, in_a[1:0]);
  assign in_is_load  = (in_ir[6:0] == OP_LOAD);
  assign in_is_store = (in_ir[6:0] == OP_STORE);
  assign cur_is_load = (ir_q[6:0] == OP_LOAD);

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  assign in_trap  = (in_is_load || in_is_store) && is_misaligned(in_size, in_a[1:0]);
  assign misalign = misalign_q;
`else
  assign in_trap = 1'b0;
`endif

  // Store data is replicated across lanes; byte enables pick the live lane.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = in_b;
    case (in_size)
      SZ_BYTE: begin
        st_be    = 4'b0001 << in_off;
        st_wdata = {4{in_b[7:0]}};
      end
      SZ_HALF: begin
        st_be    = 4'b0011 << in_off;
        st_wdata = {2{in_b[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = in_b;
      end
    endcase
  end

  load_align u_load_align (
    .rdata  (mem_rdata),
    .offset (size_offset(access_size(ir_q[14:12]), a_q[1:0])),
    .funct3 (ir_q[14:12]),
    .result (ld_result)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    out_valid_d = 1'b0;
    ir_d        = ir_q;
    rd_d        = rd_q;
    a_d         = a_q;
    pc_d        = pc_q;
`ifdef MEM_MISALIGN_TRAP_EN
    misalign_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ir_d = in_ir;
          pc_d = in_pc;
          a_d  = in_a;
          rd_d = 32'd0;
          if ((in_is_load || in_is_store) && !in_trap) begin
            state_d     = ACCESS;
            mem_req_d   = 1'b1;
            mem_we_d    = in_is_store;
            mem_be_d    = in_is_store ? st_be : 4'b1111;
            mem_addr_d  = in_a[MEM_AW+1:2];
            mem_wdata_d = in_is_store ? st_wdata : 32'd0;
          end else begin
            out_valid_d = 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_d  = in_trap;
`endif
          end
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          out_valid_d = 1'b1;
          rd_d        = cur_is_load ? ld_result : 32'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      out_valid_q <= 1'b0;
      ir_q        <= 32'd0;
      rd_q        <= 32'd0;
      a_q         <= 32'd0;
      pc_q        <= 32'd0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      out_valid_q <= out_valid_d;
      ir_q        <= ir_d;
      rd_q        <= rd_d;
      a_q         <= a_d;
      pc_q        <= pc_d;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign out_valid = out_valid_q;
  assign IR        = ir_q;
  assign RD        = rd_q;
  assign A         = a_q;
  assign PC        = pc_q;

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - directed self-checking bench for memory_access
module tb_memory_access;

  localparam int MEM_AW = 30;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_ir, in_pc, in_a, in_b;
  logic              mem_req, mem_we;
  logic [3:0]        mem_be;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  logic              out_valid;
  logic [31:0]       IR, RD, A, PC;
`ifdef MEM_MISALIGN_TRAP_EN
  logic              misalign;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  memory_access #(.MEM_AW(MEM_AW)) dut (
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign  (misalign),
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ir     (in_ir),
    .in_pc     (in_pc),
    .in_a      (in_a),
    .in_b      (in_b),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .out_valid (out_valid),
    .IR        (IR),
    .RD        (RD),
    .A         (A),
    .PC        (PC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ir, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    in_ir    = ir;
    in_pc    = pc;
    in_a     = a;
    in_b     = b;
    step();
    in_valid = 1'b0;
  endtask

  // Full memory transaction: accept, optional waits with stability checks, ack, result.
  task automatic mem_op(input string tag, input logic [31:0] ir, input logic [31:0] a,
                        input logic [31:0] b, input int waits, input logic [31:0] rdata,
                        input logic exp_we, input logic [3:0] exp_be,
                        input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_rd);
    issue(ir, 32'h0000_0400, a, b);
    check({tag, "_req"},   {31'd0, mem_req}, 32'd1);
    check({tag, "_we"},    {31'd0, mem_we}, {31'd0, exp_we});
    check({tag, "_be"},    {28'd0, mem_be}, {28'd0, exp_be});
    check({tag, "_addr"},  {2'b00, mem_addr}, exp_addr);
    check({tag, "_wdata"}, mem_wdata, exp_wdata);
    check({tag, "_rdy"},   {31'd0, in_ready}, 32'd0);
    for (int w = 0; w < waits; w++) begin
      in_valid = 1'b1;
      in_ir    = 32'h0050_0093;
      step();
      check({tag, "_wait_ov"},    {31'd0, out_valid}, 32'd0);
      check({tag, "_wait_req"},   {31'd0, mem_req}, 32'd1);
      check({tag, "_wait_be"},    {28'd0, mem_be}, {28'd0, exp_be});
      check({tag, "_wait_wdata"}, mem_wdata, exp_wdata);
    end
    in_valid  = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    step();
    mem_ack   = 1'b0;
    mem_rdata = 32'hXXXX_XXXX;
    check({tag, "_ov"},     {31'd0, out_valid}, 32'd1);
    check({tag, "_rd"},     RD, exp_rd);
    check({tag, "_ir"},     IR, ir);
    check({tag, "_req_dn"}, {31'd0, mem_req}, 32'd0);
    step();
    check({tag, "_ov_pulse"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_ir     = 32'd0;
    in_pc     = 32'd0;
    in_a      = 32'd0;
    in_b      = 32'd0;
    mem_rdata = 32'd0;
    mem_ack   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_req",   {31'd0, mem_req}, 32'd0);
    check("rst_ov",    {31'd0, out_valid}, 32'd0);
    check("rst_be",    {28'd0, mem_be}, 32'd0);
    check("rst_rd",    RD, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    check("rst_ready_after", {31'd0, in_ready}, 32'd1);

    // ADDI: latency 1, no memory request
    issue(32'h0050_0093, 32'h0000_0100, 32'd5, 32'd0);
    check("addi_ov",  {31'd0, out_valid}, 32'd1);
    check("addi_rd",  RD, 32'd0);
    check("addi_a",   A, 32'd5);
    check("addi_pc",  PC, 32'h0000_0100);
    check("addi_ir",  IR, 32'h0050_0093);
    check("addi_req", {31'd0, mem_req}, 32'd0);
    step();
    check("addi_ov_pulse", {31'd0, out_valid}, 32'd0);

    // mem_ack while idle is ignored
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("idle_ack_ov", {31'd0, out_valid}, 32'd0);

    //      tag     ir            a             b             w  rdata         we    be       addr          wdata         rd
    mem_op("lb",   32'h0001_0083, 32'h0000_0103, 32'd0,        0, 32'h8000_0000, 1'b0, 4'b1111, 32'h40,       32'd0,        32'hFFFF_FF80);
    mem_op("sh",   32'h0000_1023, 32'h0000_0102, 32'h1234_ABCD, 3, 32'd0,        1'b1, 4'b1100, 32'h40,       32'hABCD_ABCD, 32'd0);
    mem_op("lh",   32'h0000_1003, 32'h0000_0002, 32'd0,        1, 32'h8001_7FFF, 1'b0, 4'b1111, 32'h0,        32'd0,        32'hFFFF_8001);
    mem_op("lbu",  32'h0000_4003, 32'h0000_0001, 32'd0,        0, 32'h0000_AB00, 1'b0, 4'b1111, 32'h0,        32'd0,        32'h0000_00AB);
    mem_op("lhu",  32'h0000_5003, 32'h0000_0012, 32'd0,        0, 32'hF00D_0000, 1'b0, 4'b1111, 32'h4,        32'd0,        32'h0000_F00D);
    mem_op("sb",   32'h0000_0023, 32'h0000_0003, 32'h0000_0055, 0, 32'd0,        1'b1, 4'b1000, 32'h0,        32'h5555_5555, 32'd0);
    mem_op("sw",   32'h0000_2023, 32'h0000_0008, 32'hCAFE_F00D, 2, 32'd0,        1'b1, 4'b1111, 32'h2,        32'hCAFE_F00D, 32'd0);
    mem_op("lw3",  32'h0000_3003, 32'h0000_0004, 32'd0,        0, 32'h1122_3344, 1'b0, 4'b1111, 32'h1,        32'd0,        32'h1122_3344);

    // Reset in ACCESS abandons the request; a later ack is ignored
    issue(32'h0000_2003, 32'h0000_0200, 32'h0000_0200, 32'd0);
    check("rsta_req", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rsta_req_dn", {31'd0, mem_req}, 32'd0);
    check("rsta_ready",  {31'd0, in_ready}, 32'd1);
    check("rsta_ir",     IR, 32'd0);
    step();
    rst_n   = 1'b1;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("rsta_ack_ov", {31'd0, out_valid}, 32'd0);
    issue(32'h0050_0093, 32'h0000_0104, 32'd7, 32'd0);
    check("rsta_next_ov", {31'd0, out_valid}, 32'd1);
    check("rsta_next_a",  A, 32'd7);
    step();

`ifdef MEM_MISALIGN_TRAP_EN
    issue(32'h0000_2003, 32'h0000_0300, 32'h0000_0101, 32'd0);
    check("mis_ov",  {31'd0, out_valid}, 32'd1);
    check("mis_flag", {31'd0, misalign}, 32'd1);
    check("mis_req", {31'd0, mem_req}, 32'd0);
    check("mis_rd",  RD, 32'd0);
    step();
    check("mis_flag_pulse", {31'd0, misalign}, 32'd0);
    check("mis_req_after",  {31'd0, mem_req}, 32'd0);
`else
    mem_op("lw_mis", 32'h0000_2003, 32'h0000_0101, 32'd0, 0, 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'h40, 32'd0, 32'hDEAD_BEEF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 Parameter MEM_AW, default 30, SHALL set the data-memory word-address width.
REQ-002 clk  in  1  single rising-edge clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 in_valid  in  1  upstream instruction valid.
REQ-005 in_ready  out  1  block can accept an instruction.
REQ-006 in_ir, in_pc, in_a, in_b  in  32 each  instruction, PC, ALU result/byte address, store data.
REQ-007 mem_req  out  1  data-memory request.
REQ-008 mem_we  out  1  request is a store.
REQ-009 mem_be  out  4  byte-lane enables.
REQ-010 mem_addr  out  MEM_AW  word address, equal to in_a[MEM_AW+1:2].
REQ-011 mem_wdata  out  32  lane-shifted store data.
REQ-012 mem_rdata  in  32  read data, valid with mem_ack.
REQ-013 mem_ack  in  1  one-cycle completion pulse.
REQ-014 out_valid  out  1  one-cycle pulse: IR/RD/A/PC valid for the write-back stage.
REQ-015 IR, RD, A, PC  out  32 each  registered instruction, load result, ALU result, PC.

Function
REQ-016 The block SHALL use FSM states IDLE and ACCESS; in_ready SHALL be 1 exactly in IDLE.
REQ-017 In IDLE, in_valid SHALL latch in_ir, in_pc, in_a and in_b; opcode LOAD (0000011) or STORE (0100011) SHALL go to ACCESS, otherwise stay IDLE.
REQ-018 A non-memory instruction SHALL drive out_valid=1 with IR/A/PC updated and RD=0 on the next edge (latency 1).
REQ-019 In ACCESS, mem_req SHALL be 1 and mem_we/mem_be/mem_addr/mem_wdata SHALL hold stable until mem_ack.
REQ-020 On mem_ack in ACCESS: for a load, RD SHALL capture extended data; for a store, RD=0; out_valid=1 next edge; return to IDLE.
REQ-021 Latency SHALL be 2 cycles when mem_ack arrives in the first ACCESS cycle, plus 1 per wait cycle.
REQ-022 Loads by funct3 (IR[14:12]): LB 000 and LH 001 sign-extend; LW 010; LBU 100 and LHU 101 zero-extend; the lane SHALL be chosen by A[1:0].
REQ-023 Stores: SB 000 sets be=0001<<A[1:0] and replicates the byte; SH 001 sets be=0011<<{A[1],0} and replicates the half; SW 010 sets be=1111.
REQ-024 Loads SHALL drive mem_we=0 and mem_be=1111.
REQ-025 mem_ack in IDLE SHALL be ignored.
REQ-026 in_valid in ACCESS SHALL be ignored; no instruction is lost because in_ready=0.
REQ-027 Unlisted funct3 SHALL be treated as word width.
REQ-028 out_valid SHALL be low in every cycle other than those in REQ-018 and REQ-020.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, out_valid=0, and IR=RD=A=PC=0.
REQ-030 Reset during ACCESS SHALL abandon the request with no out_valid, and a later mem_ack SHALL be ignored.
REQ-031 in_ready SHALL be 1 during and after reset.

Configuration
REQ-032 With MEM_MISALIGN_TRAP_EN defined, an output port misalign (1 bit) SHALL exist.
REQ-033 With MEM_MISALIGN_TRAP_EN defined, LW/SW with A[1:0]!=0 or LH/LHU/SH with A[0]=1 SHALL skip ACCESS and issue no mem_req.
REQ-034 With MEM_MISALIGN_TRAP_EN defined, such an access SHALL pulse out_valid and misalign together at latency 1, with RD=0.
REQ-035 Without MEM_MISALIGN_TRAP_EN, the port SHALL be absent and the low address bits SHALL be masked to the access size.

Structure
REQ-036 Opcode constants (LOAD, STORE, JAL, JALR, BRANCH), funct3 width codes and the FSM state enum SHALL live in shared package rv_pkg.
REQ-037 Lane extraction and extension SHALL be a sub-module load_align (rdata, offset, funct3 -> 32-bit result).

Verification
REQ-038 ADDI IR=0x00500093, A=5 -> out_valid at edge 1, RD=0, A=5, no mem_req.
REQ-039 LB with A=0x103, mem_rdata=0x80000000 and ack in the first cycle -> mem_addr=0x40, RD=0xFFFFFF80, out_valid 2 cycles after acceptance.
REQ-040 SH with A=0x102, B=0x1234ABCD and ack after 3 wait cycles -> be=1100, wdata=0xABCDABCD held stable, out_valid on the edge after ack.
REQ-041 rst_n low in ACCESS followed by mem_ack -> mem_req drops at once, no out_valid, next instruction accepted normally.
REQ-042 LW with A=0x101 -> MEM_MISALIGN_TRAP_EN: no mem_req, misalign=1 with out_valid; without: mem_addr=0x40, normal LW.
